// File: rtl/hyperbus_cfg_seq_pkg.sv
// HyperBus boot configuration sequencer: shared types.
// State encoding, table entry bundle and a counter-width helper.
package hyperbus_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_WR,
        ST_RD,
        ST_DONE,
        ST_FAIL
    } state_e;

    // Widest address/data a table entry can carry.
    localparam int unsigned CfgMaxWidth = 64;

    typedef struct packed {
        logic [CfgMaxWidth-1:0] addr;
        logic [CfgMaxWidth-1:0] data;
        logic [CfgMaxWidth-1:0] mask;
    } cfg_entry_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n > 1) return $clog2(n);
        return 1;
    endfunction

endpackage

// File: rtl/hyperbus_cfg_seq.sv
// HyperBus boot configuration sequencer.
// After reset and a start delay it writes (and optionally reads back)
// a register table on the mst_* reg port, then passes the upstream
// slv_* reg master straight through to mst_*.
// Ports: clk_i/rst_i (sync, active high), start_i re-run pulse,
// busy_o/done_o/error_o/err_idx_o status, slv_req_*/slv_rsp_* upstream
// reg bus, mst_req_*/mst_rsp_* downstream reg bus.
module hyperbus_cfg_seq
    import hyperbus_cfg_seq_pkg::*;
#(
    parameter int unsigned NumEntries   = 4,
    parameter int unsigned RegAddrWidth = 32,
    parameter int unsigned RegDataWidth = 32,
    parameter logic [NumEntries-1:0][RegAddrWidth-1:0] CfgAddr = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] CfgData = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] CfgMask = '1,
    parameter bit          VerifyEn     = 1'b1,
    parameter int unsigned MaxRetries   = 2,
    parameter int unsigned StartDelay   = 64,
    localparam int unsigned IdxW  = cnt_width(NumEntries),
    localparam int unsigned StrbW = RegDataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [IdxW-1:0]         err_idx_o,
    input  logic [RegAddrWidth-1:0] slv_req_addr_i,
    input  logic                    slv_req_write_i,
    input  logic [RegDataWidth-1:0] slv_req_wdata_i,
    input  logic [StrbW-1:0]        slv_req_wstrb_i,
    input  logic                    slv_req_valid_i,
    output logic [RegDataWidth-1:0] slv_rsp_rdata_o,
    output logic                    slv_rsp_ready_o,
    output logic                    slv_rsp_error_o,
    output logic [RegAddrWidth-1:0] mst_req_addr_o,
    output logic                    mst_req_write_o,
    output logic [RegDataWidth-1:0] mst_req_wdata_o,
    output logic [StrbW-1:0]        mst_req_wstrb_o,
    output logic                    mst_req_valid_o,
    input  logic [RegDataWidth-1:0] mst_rsp_rdata_i,
    input  logic                    mst_rsp_ready_i,
    input  logic                    mst_rsp_error_i
);

    localparam int unsigned DlyW   = cnt_width(StartDelay + 1);
    localparam int unsigned RetryW = cnt_width(MaxRetries + 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [DlyW-1:0]   dly_q, dly_d;
    logic [IdxW-1:0]   err_idx_q, err_idx_d;
    // Set for one cycle after each accepted request so valid drops.
    logic              gap_q, gap_d;

    cfg_entry_t ent;
    logic       seq_busy;
    logic       seq_valid;
    logic       hs;
    logic       mismatch;
    logic       do_retry;
    logic       do_next;
    logic       unused_ent;

    always_comb begin
        ent.addr = 64'(CfgAddr[idx_q]);
        ent.data = 64'(CfgData[idx_q]);
        ent.mask = 64'(CfgMask[idx_q]);
    end

    assign unused_ent = ^ent;

    assign seq_busy  = (state_q == ST_WAIT) ||
                       (state_q == ST_WR) ||
                       (state_q == ST_RD);
    assign seq_valid = ((state_q == ST_WR) || (state_q == ST_RD)) &&
                       !gap_q;
    assign hs        = seq_valid && mst_rsp_ready_i;
    assign mismatch  = |((mst_rsp_rdata_i ^ ent.data[RegDataWidth-1:0]) &
                         ent.mask[RegDataWidth-1:0]);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        dly_d     = dly_q;
        err_idx_d = err_idx_q;
        gap_d     = 1'b0;
        do_retry  = 1'b0;
        do_next   = 1'b0;

        unique case (state_q)
            ST_WAIT: begin
                if (dly_q == DlyW'(StartDelay)) state_d = ST_WR;
                else dly_d = dly_q + 1'b1;
            end
            ST_WR: begin
                if (hs) begin
                    gap_d = 1'b1;
                    if (mst_rsp_error_i) do_retry = 1'b1;
                    else if (VerifyEn) state_d = ST_RD;
                    else do_next = 1'b1;
                end
            end
            ST_RD: begin
                if (hs) begin
                    gap_d = 1'b1;
                    if (mst_rsp_error_i || mismatch) do_retry = 1'b1;
                    else do_next = 1'b1;
                end
            end
            ST_DONE, ST_FAIL: begin
                // Never cut an upstream transfer that is in flight.
                if (start_i && !slv_req_valid_i) begin
                    state_d   = ST_WR;
                    idx_d     = '0;
                    retry_d   = '0;
                    err_idx_d = '0;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        if (do_retry) begin
            if (retry_q < RetryW'(MaxRetries)) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_WR;
            end else begin
                state_d   = ST_FAIL;
                err_idx_d = idx_q;
            end
        end

        if (do_next) begin
            retry_d = '0;
            if (idx_q == IdxW'(NumEntries - 1)) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_WR;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_WAIT;
            idx_q     <= '0;
            retry_q   <= '0;
            dly_q     <= '0;
            err_idx_q <= '0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            dly_q     <= dly_d;
            err_idx_q <= err_idx_d;
            gap_q     <= gap_d;
        end
    end

    assign busy_o    = seq_busy;
    assign done_o    = (state_q == ST_DONE);
    assign error_o   = (state_q == ST_FAIL);
    assign err_idx_o = err_idx_q;

    // Sequencer owns the bus while busy; otherwise a zero-latency wire.
    always_comb begin
        if (seq_busy) begin
            mst_req_addr_o  = ent.addr[RegAddrWidth-1:0];
            mst_req_write_o = (state_q == ST_WR);
            mst_req_wdata_o = ent.data[RegDataWidth-1:0];
            mst_req_wstrb_o = '1;
            mst_req_valid_o = seq_valid;
            slv_rsp_rdata_o = '0;
            slv_rsp_ready_o = 1'b0;
            slv_rsp_error_o = 1'b0;
        end else begin
            mst_req_addr_o  = slv_req_addr_i;
            mst_req_write_o = slv_req_write_i;
            mst_req_wdata_o = slv_req_wdata_i;
            mst_req_wstrb_o = slv_req_wstrb_i;
            mst_req_valid_o = slv_req_valid_i;
            slv_rsp_rdata_o = mst_rsp_rdata_i;
            slv_rsp_ready_o = mst_rsp_ready_i;
            slv_rsp_error_o = mst_rsp_error_i;
        end
    end

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Self-checking bench for hyperbus_cfg_seq.
// Reg-bus slave model with fault injection plus a table-walk scoreboard.
module tb_hyperbus_cfg_seq;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXR = 2;
    localparam int DLY  = 4;

    localparam logic [N-1:0][AW-1:0] C_ADDR = {32'h0000_0014, 32'h0000_0010};
    localparam logic [N-1:0][DW-1:0] C_DATA = {32'h0BAD_F00D, 32'h1234_5678};
    localparam logic [N-1:0][DW-1:0] C_MASK = {32'hFFFF_FFFE, 32'hFFFF_FFFF};

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy_o, done_o, error_o;
    logic [0:0]    err_idx_o;
    logic [AW-1:0] slv_addr;
    logic          slv_write;
    logic [DW-1:0] slv_wdata;
    logic [3:0]    slv_wstrb;
    logic          slv_valid;
    logic [DW-1:0] slv_rsp_rdata_o;
    logic          slv_rsp_ready_o, slv_rsp_error_o;
    logic [AW-1:0] mst_req_addr_o;
    logic          mst_req_write_o;
    logic [DW-1:0] mst_req_wdata_o;
    logic [3:0]    mst_req_wstrb_o;
    logic          mst_req_valid_o;
    logic [DW-1:0] mst_rsp_rdata_i;
    logic          mst_rsp_ready_i, mst_rsp_error_i;

    hyperbus_cfg_seq #(
        .NumEntries  (N),
        .RegAddrWidth(AW),
        .RegDataWidth(DW),
        .CfgAddr     (C_ADDR),
        .CfgData     (C_DATA),
        .CfgMask     (C_MASK),
        .VerifyEn    (1'b1),
        .MaxRetries  (MAXR),
        .StartDelay  (DLY)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .err_idx_o      (err_idx_o),
        .slv_req_addr_i (slv_addr),
        .slv_req_write_i(slv_write),
        .slv_req_wdata_i(slv_wdata),
        .slv_req_wstrb_i(slv_wstrb),
        .slv_req_valid_i(slv_valid),
        .slv_rsp_rdata_o(slv_rsp_rdata_o),
        .slv_rsp_ready_o(slv_rsp_ready_o),
        .slv_rsp_error_o(slv_rsp_error_o),
        .mst_req_addr_o (mst_req_addr_o),
        .mst_req_write_o(mst_req_write_o),
        .mst_req_wdata_o(mst_req_wdata_o),
        .mst_req_wstrb_o(mst_req_wstrb_o),
        .mst_req_valid_o(mst_req_valid_o),
        .mst_rsp_rdata_i(mst_rsp_rdata_i),
        .mst_rsp_ready_i(mst_rsp_ready_i),
        .mst_rsp_error_i(mst_rsp_error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        logic          err;
        logic [DW-1:0] rdata;
        int            cyc;
    } txn_t;

    txn_t log_q[$];
    int   cyc       = 0;
    int   w1_cnt    = 0;
    int   gap_viol  = 0;
    bit   hs_prev   = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   end_cyc   = 0;

    int   err_mode  = 0;
    int   flip_mode = 0;
    bit   stall_en  = 1'b0;
    logic rnd_err   = 1'b0;
    logic rnd_flip  = 1'b0;
    logic rnd_stall = 1'b0;
    logic [DW-1:0] rnd_pat = 32'h1;
    logic [DW-1:0] mem [2];

    always @(negedge clk) begin
        rnd_err   = ($urandom_range(0, 4) == 0);
        rnd_flip  = ($urandom_range(0, 3) == 0);
        rnd_pat   = 32'h1 << $urandom_range(0, 31);
        rnd_stall = stall_en && ($urandom_range(0, 2) == 0);
    end

    // Downstream slave: memory for the two table addresses, fault hooks.
    always_comb begin
        logic          flip;
        logic [DW-1:0] base;
        logic [DW-1:0] pat;
        mst_rsp_error_i = 1'b0;
        flip = 1'b0;
        case (err_mode)
            1: mst_rsp_error_i = mst_req_write_o &&
                                 (mst_req_addr_o == C_ADDR[1]) &&
                                 (w1_cnt == 0);
            2: mst_rsp_error_i = rnd_err;
            default: ;
        endcase
        case (flip_mode)
            1: flip = !mst_req_write_o && (mst_req_addr_o == C_ADDR[0]);
            2: flip = !mst_req_write_o && (mst_req_addr_o == C_ADDR[1]);
            3: flip = !mst_req_write_o && rnd_flip;
            default: ;
        endcase
        pat = (flip_mode == 3) ? rnd_pat : 32'h1;
        if (mst_req_addr_o == C_ADDR[0]) base = mem[0];
        else if (mst_req_addr_o == C_ADDR[1]) base = mem[1];
        else base = mst_req_addr_o ^ 32'hA5A5_0000;
        mst_rsp_rdata_i = base ^ (flip ? pat : '0);
        mst_rsp_ready_i = mst_req_valid_o && !rnd_stall;
    end

    always @(posedge clk) begin
        if (rst) begin
            mem[0] = '0;
            mem[1] = '0;
        end else if (mst_req_valid_o && mst_rsp_ready_i &&
                     mst_req_write_o && !mst_rsp_error_i) begin
            if (mst_req_addr_o == C_ADDR[0]) mem[0] = mst_req_wdata_o;
            if (mst_req_addr_o == C_ADDR[1]) mem[1] = mst_req_wdata_o;
        end
    end

    // Transaction monitor; also flags a request issued right after a handshake.
    always @(posedge clk) begin
        if (hs_prev && busy_o && mst_req_valid_o) gap_viol++;
        hs_prev = mst_req_valid_o && mst_rsp_ready_i;
        if (mst_req_valid_o && mst_rsp_ready_i) begin
            log_q.push_back('{mst_req_write_o, mst_req_addr_o,
                              mst_req_wdata_o, mst_req_wstrb_o,
                              mst_rsp_error_i, mst_rsp_rdata_i, cyc});
            if (mst_req_write_o && mst_req_addr_o == C_ADDR[1]) w1_cnt++;
        end
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        log_q.delete();
        w1_cnt   = 0;
        gap_viol = 0;
        hs_prev  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_log();
        rst = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        for (int k = 0; k < 600; k++) begin
            if (done_o || error_o) break;
            @(negedge clk);
        end
        end_cyc = cyc;
        n_checks++;
        if (!(done_o || error_o)) begin
            n_fail++;
            $display("FAIL %s timeout: done=%b error=%b, required one set",
                     nm, done_o, error_o);
        end
    endtask

    // Walk the logged transfers through the table rules and check outcome.
    task automatic check_run(input string nm);
        int p    = 0;
        bit fexp = 1'b0;
        int fidx = 0;
        bit bad  = 1'b0;
        bit stop = 1'b0;
        bit good;
        int r;
        for (int i = 0; i < N && !stop; i++) begin
            r = 0;
            for (int a = 0; a <= MAXR + 1; a++) begin
                n_checks++;
                if (p >= log_q.size() || !log_q[p].wr ||
                    log_q[p].addr !== C_ADDR[i] ||
                    log_q[p].wdata !== C_DATA[i] ||
                    log_q[p].strb !== 4'hF) begin
                    n_fail++;
                    $display("FAIL %s txn%0d: got %0d logged, required write %h<=%h",
                             nm, p, log_q.size(), C_ADDR[i], C_DATA[i]);
                    bad = 1'b1; stop = 1'b1;
                    break;
                end
                good = !log_q[p].err;
                p++;
                if (good) begin
                    n_checks++;
                    if (p >= log_q.size() || log_q[p].wr ||
                        log_q[p].addr !== C_ADDR[i]) begin
                        n_fail++;
                        $display("FAIL %s txn%0d: got %0d logged, required read %h",
                                 nm, p, log_q.size(), C_ADDR[i]);
                        bad = 1'b1; stop = 1'b1;
                        break;
                    end
                    good = !log_q[p].err &&
                           (((log_q[p].rdata ^ C_DATA[i]) & C_MASK[i]) == '0);
                    p++;
                end
                if (good) break;
                if (r < MAXR) begin
                    r++;
                end else begin
                    fexp = 1'b1; fidx = i; stop = 1'b1;
                    break;
                end
            end
        end
        if (!bad) begin
            n_checks++;
            if (p != log_q.size()) begin
                n_fail++;
                $display("FAIL %s count: got %0d transfers, required %0d",
                         nm, log_q.size(), p);
            end
            n_checks++;
            if (done_o !== !fexp || error_o !== fexp) begin
                n_fail++;
                $display("FAIL %s outcome: got done=%b error=%b, required %b %b",
                         nm, done_o, error_o, !fexp, fexp);
            end
            if (fexp) begin
                n_checks++;
                if (err_idx_o !== 1'(fidx)) begin
                    n_fail++;
                    $display("FAIL %s err_idx: got %0d, required %0d",
                             nm, err_idx_o, fidx);
                end
            end
        end
        n_checks++;
        if (gap_viol != 0) begin
            n_fail++;
            $display("FAIL %s idle gap: got %0d back-to-back requests, required 0",
                     nm, gap_viol);
        end
    endtask

    task automatic set_modes(input int em, input int fm, input bit st);
        err_mode  = em;
        flip_mode = fm;
        stall_en  = st;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, error_o, err_idx_o, mst_req_valid_o,
             slv_rsp_ready_o} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset: got busy,done,err,idx,mv,sr=%b%b%b%b%b%b, required 100000",
                     busy_o, done_o, error_o, err_idx_o, mst_req_valid_o,
                     slv_rsp_ready_o);
        end
    endtask

    task automatic test_nominal();
        int n = 0;
        set_modes(0, 0, 1'b0);
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mst_req_valid_o) begin
                n = k;
                break;
            end
        end
        n_checks++;
        if (n != DLY + 1) begin
            n_fail++;
            $display("FAIL first_valid: got cycle %0d, required %0d", n, DLY + 1);
        end
        wait_end("nominal");
        check_run("nominal");
        n_checks++;
        if (log_q.size() != 4) begin
            n_fail++;
            $display("FAIL nominal_len: got %0d, required 4", log_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (log_q[i].cyc - log_q[i-1].cyc != 2) begin
                    n_fail++;
                    $display("FAIL spacing%0d: got %0d cycles, required 2",
                             i, log_q[i].cyc - log_q[i-1].cyc);
                end
            end
            n_checks++;
            if (end_cyc != log_q[3].cyc + 1) begin
                n_fail++;
                $display("FAIL done_latency: got %0d, required %0d",
                         end_cyc - log_q[3].cyc, 1);
            end
        end
    endtask

    task automatic test_write_retry();
        set_modes(1, 0, 1'b0);
        do_reset();
        wait_end("wr_retry");
        check_run("wr_retry");
        n_checks++;
        if (log_q.size() != 5 || error_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_retry_len: got %0d err=%b, required 5 err=0",
                     log_q.size(), error_o);
        end
    endtask

    task automatic test_mismatch_fail();
        set_modes(0, 1, 1'b0);
        do_reset();
        wait_end("mm_fail");
        check_run("mm_fail");
        n_checks++;
        if (log_q.size() != 6 || error_o !== 1'b1 || done_o !== 1'b0 ||
            err_idx_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mm_fail_end: got n=%0d err=%b done=%b idx=%0d, required 6 1 0 0",
                     log_q.size(), error_o, done_o, err_idx_o);
        end
        set_modes(0, 0, 1'b0);
        @(negedge clk);
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy_o, error_o, mst_req_valid_o, mst_req_write_o} !== 4'b1011 ||
            mst_req_addr_o !== C_ADDR[0]) begin
            n_fail++;
            $display("FAIL restart_from_fail: got b,e,v,w=%b%b%b%b addr=%h, required 1011 %h",
                     busy_o, error_o, mst_req_valid_o, mst_req_write_o,
                     mst_req_addr_o, C_ADDR[0]);
        end
        wait_end("refail");
        check_run("refail");
    endtask

    task automatic test_mask_ignore();
        set_modes(0, 2, 1'b0);
        do_reset();
        wait_end("mask");
        check_run("mask");
        n_checks++;
        if (log_q.size() != 4 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_len: got %0d done=%b, required 4 1",
                     log_q.size(), done_o);
        end
    endtask

    task automatic test_passthrough();
        int viol  = 0;
        int nbusy = 0;
        set_modes(0, 0, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        slv_addr  = 32'h0000_0100;
        slv_write = 1'b0;
        slv_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_log();
        rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy_o) break;
            nbusy++;
            if (slv_rsp_ready_o || slv_rsp_error_o) viol++;
        end
        n_checks++;
        if (viol != 0 || nbusy == 0 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pt_stall: got viol=%0d busy_cycles=%0d done=%b, required 0 >0 1",
                     viol, nbusy, done_o);
        end
        n_checks++;
        if (slv_rsp_ready_o !== 1'b1 || slv_rsp_rdata_o !== 32'hA5A5_0100 ||
            mst_req_addr_o !== 32'h0000_0100 || mst_req_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pt_xfer: got rdy=%b rdata=%h addr=%h v=%b, required 1 a5a50100 00000100 1",
                     slv_rsp_ready_o, slv_rsp_rdata_o, mst_req_addr_o,
                     mst_req_valid_o);
        end
        @(negedge clk);
        slv_valid = 1'b0;
    endtask

    task automatic test_start();
        @(negedge clk);
        slv_valid = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored: got busy=%b done=%b, required 0 1",
                     busy_o, done_o);
        end
        slv_valid = 1'b0;
        @(negedge clk);
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy_o, done_o, mst_req_valid_o, mst_req_write_o} !== 4'b1011 ||
            mst_req_addr_o !== C_ADDR[0]) begin
            n_fail++;
            $display("FAIL start_restart: got b,d,v,w=%b%b%b%b addr=%h, required 1011 %h",
                     busy_o, done_o, mst_req_valid_o, mst_req_write_o,
                     mst_req_addr_o, C_ADDR[0]);
        end
        wait_end("restart");
        check_run("restart");
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        set_modes(0, 0, 1'b0);
        do_reset();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mst_req_valid_o && !mst_req_write_o) begin
                found = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (!found || mst_req_valid_o !== 1'b0 || busy_o !== 1'b1 ||
            done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got found=%b v=%b busy=%b done=%b, required 1 0 1 0",
                     found, mst_req_valid_o, busy_o, done_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int run = 0; run < 10; run++) begin
            set_modes(2, 3, 1'b1);
            do_reset();
            wait_end("random");
            check_run("random");
        end
        set_modes(0, 0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        slv_addr  = '0;
        slv_write = 1'b0;
        slv_wdata = '0;
        slv_wstrb = '0;
        slv_valid = 1'b0;
        test_reset();
        test_nominal();
        test_write_retry();
        test_mismatch_fail();
        test_mask_ignore();
        test_passthrough();
        test_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
